// File: rtl/fpu_div_exp_pkg.sv
// Shared definitions for the FP divide/sqrt exponent sequencer.
// Holds the sequencer state encoding, the format select values and the
// helpers that size the internal signed exponent and the shift saturation.
package fpu_div_exp_pkg;

    // Two guard bits give room for sign and overflow headroom over the field width.
    localparam int unsigned IEXP_PAD     = 2;
    localparam int unsigned EXP_W_DEF    = 11;
    localparam int unsigned SHCNT_W_DEF  = 6;
    localparam int unsigned IEXP_W_DEF   = EXP_W_DEF + IEXP_PAD;
    localparam int unsigned DSHIFT_SAT_DEF = (32'd1 << SHCNT_W_DEF) - 32'd1;

    localparam logic FMT_SGL = 1'b0;
    localparam logic FMT_DBL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_ITER = 3'd2,
        S_ADJ  = 3'd3,
        S_RND  = 3'd4,
        S_OUT  = 3'd5
    } state_e;

    // Internal signed exponent width for a given field width.
    function automatic int unsigned iexp_w(input int unsigned exp_w);
        return exp_w + IEXP_PAD;
    endfunction

    // All-ones value of a w-bit field (max biased exponent, shift saturation).
    function automatic int unsigned shift_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/fpu_div_exp_cls.sv
// Result exponent classifier.
// Ports: e (signed internal exponent after rounding), dbl (format),
// rz (round-toward-zero class) -> exp_c (final biased exponent),
// of_c / uf_c (overflow / underflow flags), dshift_c (denormal right-shift).
// Purely combinational; the sequencer registers the results.
module fpu_div_exp_cls
    import fpu_div_exp_pkg::*;
#(
    parameter int unsigned EXP_W   = 11,
    parameter int unsigned SEXP_W  = 8,
    parameter int unsigned SHCNT_W = 6
) (
    input  logic signed [iexp_w(EXP_W)-1:0] e,
    input  logic                            dbl,
    input  logic                            rz,
    output logic [EXP_W-1:0]                exp_c,
    output logic                            of_c,
    output logic                            uf_c,
    output logic [SHCNT_W-1:0]              dshift_c
);

    localparam int unsigned IW = iexp_w(EXP_W);
    localparam logic signed [IW-1:0] DMAX = IW'(shift_sat(EXP_W));
    localparam logic signed [IW-1:0] SMAX = IW'(shift_sat(SEXP_W));
    localparam logic signed [IW-1:0] SAT  = IW'(shift_sat(SHCNT_W));

    logic signed [IW-1:0] max_e;
    logic signed [IW-1:0] uf_amt;
    logic [EXP_W-1:0]     sat_exp;

    // Overflow saturates to infinity code, or max finite under round-to-zero.
    always_comb begin
        exp_c    = '0;
        of_c     = 1'b0;
        uf_c     = 1'b0;
        dshift_c = '0;
        max_e    = (dbl == FMT_DBL) ? DMAX : SMAX;
        sat_exp  = rz ? EXP_W'(max_e - IW'(1)) : EXP_W'(max_e);
        uf_amt   = IW'(1) - e;
        if (e >= max_e) begin
            of_c  = 1'b1;
            exp_c = sat_exp;
        end else if (e <= IW'(0)) begin
            uf_c     = 1'b1;
            dshift_c = (uf_amt >= SAT) ? {SHCNT_W{1'b1}} : uf_amt[SHCNT_W-1:0];
        end else begin
            exp_c = e[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/fpu_div_exp_seq.sv
// Handshaked exponent sequencer for the FP divide/sqrt pipe.
// Ports: rclk/rst (sync active-high); request in_vld/in_rdy with in_dbl,
// in_sqrt, in_rz, in_exp1/2, in_lz1/2; mantissa events frac_done/frac_nrm and
// rnd_vld/frac_ovf; result out_vld/out_rdy with out_exp, out_of, out_uf,
// out_dshift, out_odd.
// Build option: FPU_DIV_EXP_SQRT_EN enables the sqrt exponent path; without it
// in_sqrt is ignored and out_odd stays 0.
module fpu_div_exp_seq
    import fpu_div_exp_pkg::*;
#(
    parameter int unsigned EXP_W   = 11,
    parameter int unsigned BIAS    = 1023,
    parameter int unsigned SEXP_W  = 8,
    parameter int unsigned SBIAS   = 127,
    parameter int unsigned SHCNT_W = 6
) (
    input  logic               rclk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               in_dbl,
    input  logic               in_sqrt,
    input  logic               in_rz,
    input  logic [EXP_W-1:0]   in_exp1,
    input  logic [EXP_W-1:0]   in_exp2,
    input  logic [SHCNT_W-1:0] in_lz1,
    input  logic [SHCNT_W-1:0] in_lz2,
    input  logic               frac_done,
    input  logic               frac_nrm,
    input  logic               rnd_vld,
    input  logic               frac_ovf,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_of,
    output logic               out_uf,
    output logic [SHCNT_W-1:0] out_dshift,
    output logic               out_odd
);

    localparam int unsigned IW = iexp_w(EXP_W);

    state_e               state;
    logic                 dbl_q;
    logic                 rz_q;
    logic                 sqrt_q;
    logic [EXP_W-1:0]     e1_q;
    logic [EXP_W-1:0]     e2_q;
    logic [SHCNT_W-1:0]   lz1_q;
    logic [SHCNT_W-1:0]   lz2_q;
    logic                 nrm_q;
    logic                 odd_q;
    logic signed [IW-1:0] e_q;

    logic signed [IW-1:0] e1_eff;
    logic signed [IW-1:0] e2_eff;
    logic signed [IW-1:0] bias_i;
    logic signed [IW-1:0] lz1_i;
    logic signed [IW-1:0] lz2_i;
    logic signed [IW-1:0] calc_e;
    logic                 calc_odd;
    logic signed [IW-1:0] rnd_e;

    logic [EXP_W-1:0]     cls_exp_c;
    logic                 cls_of_c;
    logic                 cls_uf_c;
    logic [SHCNT_W-1:0]   cls_dshift_c;

`ifdef FPU_DIV_EXP_SQRT_EN
    logic signed [IW-1:0] sqrt_t;
`else
    logic unused_sqrt;
    assign unused_sqrt = in_sqrt;
`endif

    // Exponent arithmetic on the latched operands; zero exponents count as 1.
    always_comb begin
        e1_eff = (dbl_q == FMT_DBL) ? IW'(e1_q) : IW'(e1_q[SEXP_W-1:0]);
        e2_eff = (dbl_q == FMT_DBL) ? IW'(e2_q) : IW'(e2_q[SEXP_W-1:0]);
        if (e1_eff == IW'(0)) e1_eff = IW'(1);
        if (e2_eff == IW'(0)) e2_eff = IW'(1);
        bias_i   = (dbl_q == FMT_DBL) ? IW'(BIAS) : IW'(SBIAS);
        lz1_i    = IW'(lz1_q);
        lz2_i    = IW'(lz2_q);
        calc_e   = e1_eff - lz1_i - (e2_eff - lz2_i) + bias_i;
        calc_odd = 1'b0;
`ifdef FPU_DIV_EXP_SQRT_EN
        // Halve the unbiased exponent rounding toward -inf; the odd bit tells
        // the mantissa path to pre-shift the radicand.
        sqrt_t = e1_eff - lz1_i - bias_i;
        if (sqrt_q) begin
            calc_odd = sqrt_t[0];
            calc_e   = (sqrt_t >>> 1) + bias_i;
        end
`endif
        rnd_e = frac_ovf ? (e_q + IW'(1)) : e_q;
    end

    fpu_div_exp_cls #(
        .EXP_W   (EXP_W),
        .SEXP_W  (SEXP_W),
        .SHCNT_W (SHCNT_W)
    ) u_cls (
        .e        (rnd_e),
        .dbl      (dbl_q),
        .rz       (rz_q),
        .exp_c    (cls_exp_c),
        .of_c     (cls_of_c),
        .uf_c     (cls_uf_c),
        .dshift_c (cls_dshift_c)
    );

    // Sequencer with registered handshake and result outputs.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_rdy     <= 1'b0;
            out_vld    <= 1'b0;
            out_exp    <= '0;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
            out_dshift <= '0;
            out_odd    <= 1'b0;
            dbl_q      <= 1'b0;
            rz_q       <= 1'b0;
            sqrt_q     <= 1'b0;
            e1_q       <= '0;
            e2_q       <= '0;
            lz1_q      <= '0;
            lz2_q      <= '0;
            nrm_q      <= 1'b0;
            odd_q      <= 1'b0;
            e_q        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_rdy <= 1'b1;
                    if (in_vld && in_rdy) begin
                        in_rdy <= 1'b0;
                        dbl_q  <= in_dbl;
                        rz_q   <= in_rz;
`ifdef FPU_DIV_EXP_SQRT_EN
                        sqrt_q <= in_sqrt;
`else
                        sqrt_q <= 1'b0;
`endif
                        e1_q   <= in_exp1;
                        e2_q   <= in_exp2;
                        lz1_q  <= in_lz1;
                        lz2_q  <= in_lz2;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    e_q   <= calc_e;
                    odd_q <= calc_odd;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (frac_done) begin
                        nrm_q <= frac_nrm;
                        state <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    if (nrm_q) e_q <= e_q - IW'(1);
                    state <= S_RND;
                end
                S_RND: begin
                    if (rnd_vld) begin
                        out_vld    <= 1'b1;
                        out_exp    <= cls_exp_c;
                        out_of     <= cls_of_c;
                        out_uf     <= cls_uf_c;
                        out_dshift <= cls_dshift_c;
                        out_odd    <= odd_q;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    in_rdy  <= 1'b0;
                    out_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
